// File: rtl/dmem_bridge.sv
// dmem_bridge: CPU data port to a slow req/ack word memory, with a one-entry
// posted write buffer, load forwarding from that buffer and a per-access watchdog.
module dmem_bridge #(
    parameter logic [31:0] BASE    = 32'h1001_0000,
    parameter int          AW      = 11,
    parameter int          TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          d_e,
    input  logic          d_we,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   dm_out,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack,
    output logic          bus_err
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WRITE   = 2'd1;
    localparam logic [1:0] S_READ    = 2'd2;
    localparam logic [1:0] S_RD_DONE = 2'd3;

    localparam int            CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic          wb_valid_q, wb_valid_d;
    logic [AW-1:0] wb_idx_q, wb_idx_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          err_q, err_d;

    logic [31:0]   offset;
    logic          in_range;
    logic [AW-1:0] widx;
    logic          unused_byte_sel;

    // In range iff addr >= BASE and the byte offset fits in 2^AW words.
    assign offset          = addr - BASE;
    assign in_range        = (addr >= BASE) && (offset[31:AW+2] == '0);
    assign widx            = offset[AW+1:2];
    assign unused_byte_sel = ^offset[1:0];

    logic ack_ok, oor, is_st, is_ld, ld_hit, drain_ack, st_acc, accept;

    always_comb begin
        ack_ok    = mem_ack & mem_req_q;
        oor       = d_e & ~in_range;
        is_st     = d_e & in_range & d_we;
        is_ld     = d_e & in_range & ~d_we;
        ld_hit    = is_ld & wb_valid_q & (wb_idx_q == widx);
        drain_ack = (state_q == S_WRITE) & ack_ok;
        st_acc    = is_st & (~wb_valid_q | drain_ack);
        accept    = oor | st_acc | ld_hit | (is_ld & (state_q == S_RD_DONE));
    end

    // Gated by rst so the CPU is never held while the bridge is in reset.
    assign stall   = rst & d_e & ~accept;
    assign dm_out  = ld_hit ? wb_data_q : ((oor & ~d_we) ? 32'h0 : rdata_q);
    assign bus_err = (rst & oor) | err_q;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    always_comb begin
        // NOTE: every target gets a hold default first so no path can infer a latch.
        state_d     = state_q;
        wb_valid_d  = wb_valid_q;
        wb_idx_d    = wb_idx_q;
        wb_data_d   = wb_data_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (wb_valid_q) begin
                    state_d     = S_WRITE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wb_idx_q;
                    mem_wdata_d = wb_data_q;
                    cnt_d       = '0;
                end else if (st_acc) begin
                    // Store into an empty buffer is issued straight away.
                    state_d     = S_WRITE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = widx;
                    mem_wdata_d = wdata;
                    cnt_d       = '0;
                end else if (is_ld) begin
                    state_d    = S_READ;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = widx;
                    cnt_d      = '0;
                end
            end
            S_WRITE: begin
                if (ack_ok) begin
                    state_d    = S_IDLE;
                    mem_req_d  = 1'b0;
                    wb_valid_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = S_IDLE;
                    mem_req_d  = 1'b0;
                    wb_valid_d = 1'b0;
                    err_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_READ: begin
                if (ack_ok) begin
                    state_d   = S_RD_DONE;
                    mem_req_d = 1'b0;
                    rdata_d   = mem_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_RD_DONE;
                    mem_req_d = 1'b0;
                    rdata_d   = 32'hDEAD_BEEF;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RD_DONE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // A store accepted on the drain-ack edge refills the buffer it just freed.
        if (st_acc) begin
            wb_valid_d = 1'b1;
            wb_idx_d   = widx;
            wb_data_d  = wdata;
        end
    end

    // NOTE: flops take only non-blocking assignments so each samples its pre-edge inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wb_valid_q  <= 1'b0;
            wb_idx_q    <= '0;
            wb_data_q   <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wb_valid_q  <= wb_valid_d;
            wb_idx_q    <= wb_idx_d;
            wb_data_q   <= wb_data_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: a CPU driver pushes expectations from a
// word-level memory model, monitors compare CPU completions and memory writes.
module tb_dmem_bridge;
    localparam logic [31:0] TB_BASE    = 32'h1001_0000;
    localparam int          TB_AW      = 11;
    localparam int          TB_TIMEOUT = 64;
    localparam int          WORDS      = 1 << TB_AW;
    localparam logic [31:0] LAST_ADDR  = TB_BASE + 32'(4 * (WORDS - 1));
    localparam logic [31:0] END_ADDR   = TB_BASE + 32'(4 * WORDS);

    logic             clk, rst, d_e, d_we;
    logic [31:0]      addr, wdata, dm_out;
    logic             stall, mem_req, mem_we, mem_ack, bus_err;
    logic [TB_AW-1:0] mem_addr;
    logic [31:0]      mem_wdata, mem_rdata;

    dmem_bridge #(.BASE(TB_BASE), .AW(TB_AW), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .d_e(d_e), .d_we(d_we), .addr(addr), .wdata(wdata),
        .dm_out(dm_out), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .bus_err(bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { bit is_load; bit err; logic [31:0] data; } acc_exp_t;
    typedef struct { int unsigned idx; logic [31:0] data; } wr_exp_t;
    typedef struct { int cyc; logic we; int unsigned idx; } start_t;

    acc_exp_t    exp_q[$];
    wr_exp_t     exp_wr_q[$];
    start_t      starts[$];
    int          ack_cycs[$];
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] resp_mem [int unsigned];

    int n_checks = 0, n_err = 0, cyc = 0;
    int err_seen = 0, exp_err_total = 0, last_len = 0, fixed_delay = 0;
    bit mon_en = 0, ack_never = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int unsigned idx);
        return 32'hC0DE_0000 + idx * 32'd7 + 32'd1;
    endfunction

    function automatic logic [31:0] ref_read(input int unsigned idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
    endfunction

    function automatic logic [31:0] resp_read(input int unsigned idx);
        return resp_mem.exists(idx) ? resp_mem[idx] : init_word(idx);
    endfunction

    function automatic bit tb_in_range(input logic [31:0] a);
        longint la, lb;
        la = longint'(a);
        lb = longint'(TB_BASE);
        return (la >= lb) && (la < lb + 4 * WORDS);
    endfunction

    // CPU driver: one access, held until accepted.
    task automatic cpu_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input bit rd_timeout, output int stalls, output int acc_cyc);
        acc_exp_t    e;
        int unsigned idx;
        bit          inr;
        inr       = tb_in_range(a);
        idx       = (a - TB_BASE) >> 2;
        e.is_load = !we;
        e.err     = !inr || rd_timeout;
        e.data    = 32'h0;
        if (inr) begin
            if (we) begin
                ref_mem[idx] = d;
                exp_wr_q.push_back('{idx, d});
            end else begin
                e.data = rd_timeout ? 32'hDEAD_BEEF : ref_read(idx);
            end
        end
        if (e.err) exp_err_total++;
        exp_q.push_back(e);
        d_e = 1'b1; d_we = we; addr = a; wdata = d;
        stalls  = 0;
        acc_cyc = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!stall) begin
                acc_cyc = cyc;
                break;
            end
            stalls++;
        end
        if (acc_cyc < 0) begin
            $display("FAIL accept_bound: access at %h never accepted", a);
            $fatal(1, "bench stopped");
        end
        @(posedge clk); #1;
        d_e = 1'b0; d_we = 1'b0;
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while ((exp_wr_q.size() != 0 || exp_q.size() != 0 || mem_req) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            $display("FAIL quiet_bound: bridge did not drain");
            $fatal(1, "bench stopped");
        end
        @(posedge clk); #1;
    endtask

    // Memory responder and write-side monitor.
    initial begin : responder
        bit               in_txn, prev_ack, ok;
        int               w_cnt, cur_delay, req_len;
        logic             st_we;
        logic [TB_AW-1:0] st_addr;
        logic [31:0]      st_wdata;
        wr_exp_t          w;
        in_txn = 0; prev_ack = 0; w_cnt = 0; cur_delay = 0; req_len = 0;
        st_we = 0; st_addr = '0; st_wdata = '0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (mon_en && prev_ack) check("req_low_after_ack", {31'b0, mem_req}, 32'h0);
            prev_ack = 0;
            if (in_txn && !mem_req) begin
                in_txn   = 0;
                last_len = req_len;
            end
            if (mem_req) begin
                if (!in_txn) begin
                    in_txn    = 1;
                    w_cnt     = 0;
                    req_len   = 0;
                    cur_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
                    st_we     = mem_we;
                    st_addr   = mem_addr;
                    st_wdata  = mem_wdata;
                    starts.push_back('{cyc, mem_we, int'(mem_addr)});
                end
                req_len++;
                if (!ack_never && w_cnt >= cur_delay) begin
                    mem_ack  = 1'b1;
                    prev_ack = 1;
                    in_txn   = 0;
                    last_len = req_len;
                    ack_cycs.push_back(cyc);
                    ok = (mem_we === st_we) && (mem_addr === st_addr) && (mem_wdata === st_wdata);
                    check("mem_stable", {31'b0, ok}, 32'h1);
                    if (mem_we) begin
                        if (exp_wr_q.size() == 0) begin
                            check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
                        end else begin
                            w = exp_wr_q.pop_front();
                            check("wr_addr", 32'(mem_addr), w.idx);
                            check("wr_data", mem_wdata, w.data);
                        end
                        resp_mem[int'(mem_addr)] = mem_wdata;
                    end else begin
                        mem_rdata = resp_read(int'(mem_addr));
                    end
                end else if (!ack_never) begin
                    w_cnt++;
                end
            end
        end
    end

    // CPU-side monitor.
    always @(negedge clk) begin : cpu_mon
        acc_exp_t e;
        if (mon_en && rst && d_e && !stall) begin
            if (exp_q.size() == 0) begin
                check("unexpected_accept", addr, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                if (e.is_load) check("load_data", dm_out, e.data);
                check("bus_err_on_access", {31'b0, bus_err}, {31'b0, e.err});
            end
        end
        if (mon_en && bus_err) err_seen++;
    end

    initial begin : main
        int s1, s2, a1, a2, e0;
        rst = 1'b0; d_e = 1'b0; d_we = 1'b0; addr = 32'h0; wdata = 32'h0;

        #12;
        d_e = 1'b1; d_we = 1'b0; addr = TB_BASE + 32'd8;
        #1;
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_dm_out", dm_out, 32'h0);
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_mem_we", {31'b0, mem_we}, 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_bus_err", {31'b0, bus_err}, 32'h0);
        d_e = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        mon_en = 1;
        @(posedge clk); #1;

        // Store then fetch.
        fixed_delay = 3; starts.delete(); ack_cycs.delete();
        cpu_op(1'b1, TB_BASE + 32'h10, 32'hA5A5_0001, 0, s1, a1);
        check("sf_stall", s1, 0);
        wait_quiet();
        check("sf_txn_count", starts.size(), 1);
        if (starts.size() >= 1 && ack_cycs.size() >= 1) begin
            check("sf_issue_cycle", starts[0].cyc, a1 + 1);
            check("sf_we", {31'b0, starts[0].we}, 32'h1);
            check("sf_addr", starts[0].idx, 4);
            check("sf_ack_wait", ack_cycs[0] - starts[0].cyc, 3);
        end
        check("sf_wb_cleared", {31'b0, dut.wb_valid_q}, 32'h0);

        // Back-to-back stores.
        starts.delete(); ack_cycs.delete();
        cpu_op(1'b1, TB_BASE + 32'd16, $urandom, 0, s1, a1);
        cpu_op(1'b1, TB_BASE + 32'd20, $urandom, 0, s2, a2);
        check("b2b_first_stall", s1, 0);
        check("b2b_second_stall", s2, 3);
        wait_quiet();
        check("b2b_txn_count", starts.size(), 2);
        if (starts.size() >= 2 && ack_cycs.size() >= 1) begin
            check("b2b_accept_on_ack", a2, ack_cycs[0]);
            check("b2b_second_issue", starts[1].cyc, a2 + 2);
            check("b2b_second_addr", starts[1].idx, 5);
        end

        // Forwarding with a memory that is not answering.
        fixed_delay = 0; starts.delete(); ack_cycs.delete();
        ack_never = 1;
        cpu_op(1'b1, TB_BASE + 32'd28, 32'h1234_5678, 0, s1, a1);
        cpu_op(1'b0, TB_BASE + 32'd28, 32'h0, 0, s2, a2);
        ack_never = 0;
        check("fwd_store_stall", s1, 0);
        check("fwd_load_stall", s2, 0);
        wait_quiet();
        check("fwd_no_read", starts.size(), 1);

        // Ordering: pending drain precedes the read.
        starts.delete(); ack_cycs.delete();
        cpu_op(1'b1, TB_BASE + 32'd32, 32'h0BAD_F00D, 0, s1, a1);
        cpu_op(1'b0, TB_BASE + 32'd36, 32'h0, 0, s2, a2);
        check("ord_load_stall", s2, 3);
        wait_quiet();
        check("ord_txn_count", starts.size(), 2);
        if (starts.size() >= 2 && ack_cycs.size() >= 1) begin
            check("ord_first_is_write", {31'b0, starts[0].we}, 32'h1);
            check("ord_second_is_read", {31'b0, starts[1].we}, 32'h0);
            check("ord_read_idx", starts[1].idx, 9);
            check("ord_read_after_ack", {31'b0, starts[1].cyc > ack_cycs[0]}, 32'h1);
        end

        // Read timeout.
        e0 = err_seen;
        ack_never = 1;
        cpu_op(1'b0, TB_BASE + 32'd8, 32'h0, 1, s1, a1);
        check("to_stall", s1, TB_TIMEOUT + 1);
        check("to_req_len", last_len, TB_TIMEOUT);
        check("to_err_pulses", err_seen - e0, 1);
        ack_never = 0;
        wait_quiet();

        // Out-of-range load and store.
        starts.delete(); e0 = err_seen;
        cpu_op(1'b0, 32'h0000_0040, 32'h0, 0, s1, a1);
        cpu_op(1'b1, END_ADDR, 32'hFFFF_0000, 0, s2, a2);
        repeat (3) begin @(posedge clk); #1; end
        check("oor_load_stall", s1, 0);
        check("oor_store_stall", s2, 0);
        check("oor_no_req", starts.size(), 0);
        check("oor_err_pulses", err_seen - e0, 2);

        // Randomised traffic.
        fixed_delay = -1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra;
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 60)      ra = TB_BASE + 32'(4 * $urandom_range(0, 15));
            else if (r < 67) ra = TB_BASE;
            else if (r < 74) ra = LAST_ADDR;
            else if (r < 84) ra = TB_BASE + 32'(4 * $urandom_range(0, WORDS - 1));
            else if (r < 90) ra = TB_BASE - 32'(4 * $urandom_range(1, 8));
            else if (r < 96) ra = END_ADDR + 32'(4 * $urandom_range(0, 8));
            else             ra = 32'(4 * $urandom_range(0, 64));
            cpu_op(1'($urandom_range(0, 1)), ra, $urandom, 0, s1, a1);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        wait_quiet();
        check("total_err_pulses", err_seen, exp_err_total);

        // Asynchronous reset in the middle of a read.
        ack_never = 1; mon_en = 0;
        d_e = 1'b1; d_we = 1'b0; addr = TB_BASE + 32'd12;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_req", {31'b0, mem_req}, 32'h1);
        check("pre_rst_stall", {31'b0, stall}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_mem_req", {31'b0, mem_req}, 32'h0);
        check("arst_stall", {31'b0, stall}, 32'h0);
        check("arst_dm_out", dm_out, 32'h0);
        check("arst_bus_err", {31'b0, bus_err}, 32'h0);
        d_e = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
